fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch pipeline sequencer between the instruction address state, the I-cache request/response ports and the decode stage. It owns the fetch PC and issues in-order I-cache requests under a credit limit. It buffers returned instructions in a small queue toward decode. On branch/exception redirects it discards stale in-flight responses.

Parameters:
ADDR, 32, address width
INST, 32, instruction width; PC increments by INST/8 bytes
FQ_DEPTH, 4, fetch queue entries and maximum outstanding-plus-buffered instructions (power of 2, >=2)
RESET_PC, 0, fetch PC loaded at reset

Ports:
clk  in  1  clock
reset_  in  1  synchronous reset, active-high (1 = reset)
redirect_valid  in  1  redirect fetch to redirect_pc this cycle
redirect_pc  in  ADDR  redirect target
ic_req_valid  out  1  I-cache fetch request
ic_req_pc  out  ADDR  request address
ic_req_ready  in  1  I-cache accepts request
ic_resp_valid  in  1  I-cache returns one instruction, in request order
ic_resp_pc  in  ADDR  PC of returned instruction
ic_resp_inst  in  INST  returned instruction
dec_valid  out  1  instruction valid toward decode
dec_ready  in  1  decode accepts
dec_pc  out  ADDR  instruction PC
dec_inst  out  INST  instruction
busy  out  1  outstanding requests or queue non-empty

Behaviour:
- Counters: outstanding (oc) and queue count (qc), each $clog2(FQ_DEPTH+1) bits. drop_cnt has the same width.
- Reset (synchronous, any state): pc=RESET_PC, oc=qc=drop_cnt=0, queue pointers 0, state=BOOT. All outputs 0 except ic_req_pc=RESET_PC.
- FSM states: BOOT, RUN, DRAIN.
  - BOOT lasts exactly 1 cycle, then RUN. No requests are issued in BOOT.
  - RUN issues requests normally.
  - DRAIN issues no requests and discards responses until drop_cnt=0.
- Request issue:
  - ic_req_valid = (state==RUN) & !redirect_valid & (oc+qc < FQ_DEPTH).
  - ic_req_pc = pc.
  - Accept means ic_req_valid & ic_req_ready. On accept: pc += INST/8 (wrap modulo 2^ADDR) and oc += 1.
  - ic_req_valid may deassert without acceptance (redirect or DRAIN entry). The I-cache treats unaccepted requests as withdrawn.
- Response (ic_resp_valid):
  - Always oc -= 1.
  - If drop_cnt>0 or redirect_valid is high that cycle, the response is discarded and drop_cnt -= 1 when nonzero.
  - Otherwise {ic_resp_pc, ic_resp_inst} is pushed to the queue. The credit rule guarantees the queue cannot overflow.
  - Response with oc==0 is a protocol error: ignored, counters unchanged, flagged by simulation assertion.
- Decode side:
  - dec_valid = (qc>0) & !redirect_valid.
  - dec_pc/dec_inst = queue head.
  - Pop on dec_valid & dec_ready.
  - Push and pop in the same cycle leave qc unchanged. Pop from a full queue plus push is legal.
  - Output is registered from the queue; data enters the queue the cycle after ic_resp_valid. Minimum response-to-dec_valid latency is 1 cycle.
- Redirect (redirect_valid=1, any state except BOOT):
  - pc <= redirect_pc.
  - Queue flushed: qc=0, pointers reset.
  - No request is accepted that cycle.
  - drop_cnt <= oc - (ic_resp_valid ? 1 : 0), i.e. all still-in-flight responses are stale.
  - Next state: DRAIN if the new drop_cnt>0, else RUN.
  - A redirect while in DRAIN recomputes drop_cnt the same way and stays in or leaves DRAIN accordingly.
  - A redirect in BOOT is ignored.
- DRAIN -> RUN on the cycle after drop_cnt reaches 0. The first request from redirect_pc is issued in RUN.
- busy = (oc!=0) | (qc!=0) | (state!=RUN).
- Requests are issued at most one per cycle; responses are accepted at most one per cycle.

Test Plan:
- Reset release, ic_req_ready=1, 1-cycle cache latency, dec_ready=1 -> first request pc=0x0 in the 2nd cycle after reset; dec_pc sequence 0x0,0x4,0x8 with one instruction per cycle steady state.
- dec_ready=0, cache always ready -> exactly 4 requests (0x0..0xC) issued, ic_req_valid held 0 afterwards. Release dec_ready -> 4 instructions drained in order, then fetch resumes at 0x10.
- 3 requests in flight (oc=3), redirect to 0x100 with no same-cycle response -> queue flushed, DRAIN entered, next 3 responses discarded (dec_valid stays 0), first new ic_req_pc=0x100 one cycle after the 3rd discarded response.
- Redirect coinciding with a response while oc=1 -> response discarded, drop_cnt=0, state RUN, ic_req_pc=0x100 on the next cycle.
- Second redirect to 0x200 during DRAIN -> pc=0x200, drop_cnt=remaining oc, no instruction from 0x100 or older reaches decode.
- ic_req_ready toggling 0/1 with variable cache latency 1-5 cycles, random dec_ready -> in-order contiguous dec_pc stream, oc+qc never exceeds 4. Reset asserted mid-stream -> all counters 0 and ic_req_pc=RESET_PC on the next cycle.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bundle: redirect input, I-cache request/response ports,
// decode handoff and the busy indication.
interface fetch_ctrl_if #(
   parameter int ADDR = 32,
   parameter int INST = 32
) ();
   logic            redirect_valid;
   logic [ADDR-1:0] redirect_pc;
   logic            ic_req_valid;
   logic [ADDR-1:0] ic_req_pc;
   logic            ic_req_ready;
   logic            ic_resp_valid;
   logic [ADDR-1:0] ic_resp_pc;
   logic [INST-1:0] ic_resp_inst;
   logic            dec_valid;
   logic            dec_ready;
   logic [ADDR-1:0] dec_pc;
   logic [INST-1:0] dec_inst;
   logic            busy;

   // Sequencer side.
   modport master (
      input  redirect_valid, redirect_pc,
      output ic_req_valid, ic_req_pc,
      input  ic_req_ready,
      input  ic_resp_valid, ic_resp_pc, ic_resp_inst,
      output dec_valid,
      input  dec_ready,
      output dec_pc, dec_inst,
      output busy
   );

   // Environment side (I-cache, decode, redirect source).
   modport slave (
      output redirect_valid, redirect_pc,
      input  ic_req_valid, ic_req_pc,
      output ic_req_ready,
      output ic_resp_valid, ic_resp_pc, ic_resp_inst,
      input  dec_valid,
      output dec_ready,
      input  dec_pc, dec_inst,
      input  busy
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch pipeline sequencer: owns the fetch PC, issues in-order I-cache
// requests under a credit limit of FQ_DEPTH (outstanding + buffered), buffers
// responses in a small queue toward decode, and discards stale in-flight
// responses after a redirect.
module fetch_ctrl #(
   parameter int              ADDR     = 32,
   parameter int              INST     = 32,
   parameter int              FQ_DEPTH = 4,
   parameter logic [ADDR-1:0] RESET_PC = '0
) (
   input logic         clk,
   input logic         reset_,
   fetch_ctrl_if.master bus
);

   localparam int CW = $clog2(FQ_DEPTH + 1);
   localparam int PW = $clog2(FQ_DEPTH);
   localparam logic [ADDR-1:0] PC_STEP = ADDR'(INST / 8);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [ADDR-1:0] pc, pc_nxt;
   logic [CW-1:0]   oc, oc_nxt;
   logic [CW-1:0]   qc, qc_nxt;
   logic [CW-1:0]   drop_cnt, drop_nxt;
   logic [PW-1:0]   wr_ptr, wr_ptr_nxt;
   logic [PW-1:0]   rd_ptr, rd_ptr_nxt;

   logic [ADDR-1:0] q_pc   [FQ_DEPTH];
   logic [INST-1:0] q_inst [FQ_DEPTH];

   logic [CW:0]     occupancy;
   logic            redir;
   logic            req_valid;
   logic            accept;
   logic            resp_ok;
   logic            push;
   logic            pop;
   logic            deq_valid;

   // Handshake qualifiers derived from current state and inputs.
   always_comb begin
      occupancy = {1'b0, oc} + {1'b0, qc};
      redir     = bus.redirect_valid && (state != BOOT);
      req_valid = (state == RUN) && !bus.redirect_valid &&
                  (occupancy < (CW+1)'(FQ_DEPTH));
      accept    = req_valid && bus.ic_req_ready;
      // A response with nothing outstanding is a protocol error and is ignored.
      resp_ok   = bus.ic_resp_valid && (oc != '0);
      push      = resp_ok && (drop_cnt == '0) && !bus.redirect_valid;
      deq_valid = (qc != '0) && !bus.redirect_valid;
      pop       = deq_valid && bus.dec_ready;
   end

   // Next-state computation for PC, counters, queue pointers and FSM.
   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      qc_nxt     = qc;
      drop_nxt   = drop_cnt;
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      oc_nxt     = oc + CW'(accept) - CW'(resp_ok);

      if (redir) begin
         // Everything still in flight after this cycle is stale; since no
         // request is accepted during a redirect this equals oc_nxt.
         pc_nxt     = bus.redirect_pc;
         qc_nxt     = '0;
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
         drop_nxt   = oc - CW'(resp_ok);
      end else begin
         if (accept) begin
            pc_nxt = pc + PC_STEP;
         end
         qc_nxt = qc + CW'(push) - CW'(pop);
         if (push) begin
            wr_ptr_nxt = wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr_nxt = rd_ptr + PW'(1);
         end
         if (resp_ok && (drop_cnt != '0)) begin
            drop_nxt = drop_cnt - CW'(1);
         end
      end

      // RUN/DRAIN selection follows the post-update drop count, so the cycle
      // after the last stale response is already RUN.
      case (state)
         BOOT:       state_nxt = RUN;
         RUN, DRAIN: state_nxt = (drop_nxt != '0) ? DRAIN : RUN;
         default:    state_nxt = BOOT;
      endcase
   end

   // State, PC and counter registers.
   always_ff @(posedge clk) begin
      if (reset_) begin
         state    <= BOOT;
         pc       <= RESET_PC;
         oc       <= '0;
         qc       <= '0;
         drop_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         oc       <= oc_nxt;
         qc       <= qc_nxt;
         drop_cnt <= drop_nxt;
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
      end
   end

   // Fetch queue storage; cleared at reset so the decode outputs read zero.
   always_ff @(posedge clk) begin
      if (reset_) begin
         for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
            q_pc[i]   <= '0;
            q_inst[i] <= '0;
         end
      end else if (push) begin
         q_pc[wr_ptr]   <= bus.ic_resp_pc;
         q_inst[wr_ptr] <= bus.ic_resp_inst;
      end
   end

   assign bus.ic_req_valid = req_valid;
   assign bus.ic_req_pc    = pc;
   assign bus.dec_valid    = deq_valid;
   assign bus.dec_pc       = q_pc[rd_ptr];
   assign bus.dec_inst     = q_inst[rd_ptr];
   // Held reset forces busy low so every output except ic_req_pc reads zero.
   assign bus.busy         = !reset_ &&
                             ((oc != '0) || (qc != '0) || (state != RUN));

   resp_needs_outstanding: assert property (
      @(posedge clk) disable iff (reset_) !(bus.ic_resp_valid && (oc == '0))
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: in-order I-cache model with configurable
// latency, decode stream checker, redirect/drain scenarios and credit bound.
module tb_fetch_ctrl;
   localparam int ADDR     = 32;
   localparam int INST     = 32;
   localparam int FQ_DEPTH = 4;
   localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic reset_ = 1'b1;
   always #5 clk = ~clk;

   fetch_ctrl_if #(.ADDR(ADDR), .INST(INST)) bus ();

   fetch_ctrl #(
      .ADDR(ADDR), .INST(INST), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .reset_(reset_), .bus(bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int          cyc = 0;
   logic [31:0] pend_pc[$];
   int          pend_due[$];
   int          nreq = 0;
   int          ndec = 0;
   int          last_resp_cyc = 0;
   logic [31:0] exp_dec = '0;
   bit          rand_lat = 0;
   int          lat_fix = 1;
   bit          track = 0;
   int          qmodel = 0;
   int          max_occ = 0;
   bit          saw_dec;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One clock: observe handshakes at negedge, then drive the cache response.
   task automatic tick();
      int due;
      int occ;
      @(negedge clk);
      if (reset_) begin
         pend_pc.delete();
         pend_due.delete();
         qmodel = 0;
      end else begin
         if (track) begin
            occ = pend_pc.size() + qmodel;
            if (occ > max_occ) max_occ = occ;
         end
         if (bus.dec_valid && bus.dec_ready) begin
            check("dec_pc", bus.dec_pc, exp_dec);
            check("dec_inst", bus.dec_inst, exp_dec ^ MAGIC);
            exp_dec += 32'd4;
            ndec++;
            qmodel--;
         end
         if (bus.ic_resp_valid) begin
            void'(pend_pc.pop_front());
            void'(pend_due.pop_front());
            last_resp_cyc = cyc;
            qmodel++;
         end
         if (bus.ic_req_valid && bus.ic_req_ready) begin
            due = cyc + (rand_lat ? int'($urandom_range(1, 5)) : lat_fix);
            if (pend_due.size() > 0 && due <= pend_due[$]) due = pend_due[$] + 1;
            pend_pc.push_back(bus.ic_req_pc);
            pend_due.push_back(due);
            nreq++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!reset_ && pend_pc.size() > 0 && pend_due[0] <= cyc) begin
         bus.ic_resp_valid = 1'b1;
         bus.ic_resp_pc    = pend_pc[0];
         bus.ic_resp_inst  = pend_pc[0] ^ MAGIC;
      end else begin
         bus.ic_resp_valid = 1'b0;
         bus.ic_resp_pc    = '0;
         bus.ic_resp_inst  = '0;
      end
   endtask

   // One reset cycle; returns in the BOOT cycle with reset released.
   task automatic do_reset();
      reset_ = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.ic_req_ready = 1'b0;
      bus.dec_ready = 1'b0;
      tick();
      reset_ = 1'b0;
      nreq = 0;
      ndec = 0;
      exp_dec = '0;
   endtask

   // Bring three requests in flight with long latency, then hold ready low.
   task automatic three_in_flight();
      do_reset();
      lat_fix = 10;
      rand_lat = 0;
      bus.ic_req_ready = 1'b1;
      bus.dec_ready = 1'b1;
      for (int i = 0; i < 20 && nreq < 3; i++) begin
         tick();
         if (nreq == 3) bus.ic_req_ready = 1'b0;
      end
      check("three_accepted", nreq, 3);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.ic_req_ready   = 1'b0;
      bus.ic_resp_valid  = 1'b0;
      bus.ic_resp_pc     = '0;
      bus.ic_resp_inst   = '0;
      bus.dec_ready      = 1'b0;

      // Reset state, boot cycle, first fetches with 1-cycle cache.
      tick();
      tick();
      check("rst_req_valid", bus.ic_req_valid, 0);
      check("rst_req_pc", bus.ic_req_pc, 0);
      check("rst_dec_valid", bus.dec_valid, 0);
      check("rst_busy", bus.busy, 0);
      reset_ = 1'b0;
      bus.ic_req_ready = 1'b1;
      bus.dec_ready = 1'b1;
      lat_fix = 1;
      #1;
      check("boot_no_req", bus.ic_req_valid, 0);
      check("boot_busy", bus.busy, 1);
      tick();
      check("first_req_valid", bus.ic_req_valid, 1);
      check("first_req_pc", bus.ic_req_pc, 32'h0);
      tick();
      tick();
      check("first_dec_valid", bus.dec_valid, 1);
      check("first_dec_pc", bus.dec_pc, 32'h0);
      tick();
      check("second_dec_pc", bus.dec_pc, 32'h4);
      tick();
      check("third_dec_pc", bus.dec_pc, 32'h8);
      repeat (6) tick();
      check("steady_rate", ndec, 8);

      // Decode stalled: credit limit stops fetch at four, then drain/resume.
      do_reset();
      bus.ic_req_ready = 1'b1;
      lat_fix = 1;
      repeat (10) tick();
      check("stall_req_count", nreq, 4);
      check("stall_req_held", bus.ic_req_valid, 0);
      check("stall_dec_valid", bus.dec_valid, 1);
      check("stall_dec_pc", bus.dec_pc, 32'h0);
      bus.dec_ready = 1'b1;
      #1;
      check("full_no_req", bus.ic_req_valid, 0);
      tick();
      check("resume_req_valid", bus.ic_req_valid, 1);
      check("resume_req_pc", bus.ic_req_pc, 32'h10);
      repeat (8) tick();
      check("drain_count", ndec, 9);

      // Redirect with three in flight and no same-cycle response.
      three_in_flight();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h100;
      exp_dec = 32'h100;
      #1;
      check("redir_no_req", bus.ic_req_valid, 0);
      check("redir_no_dec", bus.dec_valid, 0);
      tick();
      bus.redirect_valid = 1'b0;
      bus.ic_req_ready = 1'b1;
      #1;
      check("drain_busy", bus.busy, 1);
      check("drain_no_req", bus.ic_req_valid, 0);
      saw_dec = 0;
      for (int i = 0; i < 40 && !bus.ic_req_valid; i++) begin
         tick();
         if (bus.dec_valid) saw_dec = 1;
      end
      check("redir_req_valid", bus.ic_req_valid, 1);
      check("redir_req_pc", bus.ic_req_pc, 32'h100);
      check("redir_req_timing", cyc, last_resp_cyc + 1);
      check("redir_no_stale_dec", saw_dec, 0);
      check("redir_all_resp_done", pend_pc.size(), 0);
      repeat (20) tick();
      check("redir_resumed", ndec > 0, 1);

      // Redirect coinciding with the only outstanding response.
      do_reset();
      lat_fix = 3;
      bus.ic_req_ready = 1'b1;
      bus.dec_ready = 1'b1;
      for (int i = 0; i < 10 && nreq < 1; i++) begin
         tick();
         if (nreq == 1) bus.ic_req_ready = 1'b0;
      end
      for (int i = 0; i < 10 && !bus.ic_resp_valid; i++) tick();
      check("coincide_resp_seen", bus.ic_resp_valid, 1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h100;
      exp_dec = 32'h100;
      #1;
      check("coincide_no_dec", bus.dec_valid, 0);
      tick();
      bus.redirect_valid = 1'b0;
      bus.ic_req_ready = 1'b1;
      #1;
      check("coincide_req_valid", bus.ic_req_valid, 1);
      check("coincide_req_pc", bus.ic_req_pc, 32'h100);
      check("coincide_not_busy", bus.busy, 0);
      repeat (8) tick();
      check("coincide_resumed", ndec > 0, 1);

      // Second redirect while draining, landing on a discarded response.
      three_in_flight();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h100;
      exp_dec = 32'h100;
      tick();
      bus.redirect_valid = 1'b0;
      bus.ic_req_ready = 1'b1;
      for (int i = 0; i < 30 && !bus.ic_resp_valid; i++) tick();
      check("redir2_resp_seen", bus.ic_resp_valid, 1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h200;
      exp_dec = 32'h200;
      #1;
      check("redir2_no_req", bus.ic_req_valid, 0);
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      saw_dec = 0;
      for (int i = 0; i < 30 && !bus.ic_req_valid; i++) begin
         tick();
         if (bus.dec_valid) saw_dec = 1;
      end
      check("redir2_req_pc", bus.ic_req_pc, 32'h200);
      check("redir2_req_timing", cyc, last_resp_cyc + 1);
      check("redir2_no_stale_dec", saw_dec, 0);
      repeat (20) tick();
      check("redir2_resumed", ndec > 0, 1);

      // Random ready/latency traffic with credit bound, then mid-stream reset.
      do_reset();
      rand_lat = 1;
      track = 1;
      max_occ = 0;
      for (int i = 0; i < 400; i++) begin
         bus.ic_req_ready = 1'($urandom_range(0, 1));
         bus.dec_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      check("rand_credit_bound", max_occ <= FQ_DEPTH, 1);
      check("rand_progress", ndec >= 50, 1);
      check("rand_pc_moved", bus.ic_req_pc != 32'h0, 1);
      track = 0;
      reset_ = 1'b1;
      tick();
      check("midrst_req_pc", bus.ic_req_pc, 32'h0);
      check("midrst_req_valid", bus.ic_req_valid, 0);
      check("midrst_dec_valid", bus.dec_valid, 0);
      check("midrst_busy", bus.busy, 0);
      reset_ = 1'b0;
      rand_lat = 0;
      lat_fix = 2;
      ndec = 0;
      exp_dec = '0;
      bus.ic_req_ready = 1'b1;
      bus.dec_ready = 1'b1;
      #1;
      check("midrst_boot_no_req", bus.ic_req_valid, 0);
      tick();
      check("midrst_req_restart", bus.ic_req_valid, 1);
      check("midrst_req_pc0", bus.ic_req_pc, 32'h0);
      repeat (10) tick();
      check("midrst_resumed", ndec > 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
